// File: rtl/mmio_uart_tx_if.sv
// Processor data-memory bus slice seen by the MMIO UART transmitter.
interface mmio_uart_tx_if;
  logic [31:0] mem_addr;
  logic        mem_oe;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_we;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_addr, mem_oe, mem_wdata, mem_we,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_addr, mem_oe, mem_wdata, mem_we,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO, status register and
// single-cycle-latency read responses.
module mmio_uart_tx #(
  parameter logic [31:0] BASE     = 32'hf0000000,
  parameter int unsigned BAUD_DIV = 868,
  parameter int unsigned FIFO_LOG = 4
) (
  input  logic          clk,
  input  logic          rst,
  mmio_uart_tx_if.slave bus,
  output logic          uart_txd
);

  localparam int unsigned DEPTH  = 1 << FIFO_LOG;
  localparam int unsigned CNT_W  = FIFO_LOG + 1;
  localparam int unsigned BAUD_W = $clog2(BAUD_DIV);
  localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(BAUD_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state, state_next;
  logic [BAUD_W-1:0]   baud_cnt, baud_next;
  logic [2:0]          bit_idx, bit_next;
  logic [7:0]          shift, shift_next;
  logic [FIFO_LOG-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0]    count, count_next;
  logic                ovf, ovf_next;
  logic                txd_next;
  logic [31:0]         rdata_next, rd_val;
  logic                ready_next;
  logic [7:0]          fifo_mem [DEPTH];

  logic       sel, is_rd, push_req, clr_ovf, full, busy, pop, push;
  logic [1:0] off;
  logic       unused_bits;

  assign sel      = bus.mem_oe && (bus.mem_addr[31:4] == BASE[31:4]);
  assign off      = bus.mem_addr[3:2];
  assign is_rd    = sel && (bus.mem_we == 4'h0);
  assign push_req = sel && (off == 2'd1) && bus.mem_we[0];
  assign clr_ovf  = sel && (off == 2'd2) && (bus.mem_we != 4'h0);
  assign full     = (count == CNT_W'(DEPTH));
  assign busy     = (state != IDLE) || (count != '0);
  // A full FIFO still accepts a byte when the FSM frees a slot the same cycle.
  assign push     = push_req && (!full || pop);
  assign unused_bits = ^{bus.mem_wdata[31:8], bus.mem_addr[1:0]};

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      baud_cnt      <= '0;
      bit_idx       <= '0;
      shift         <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      ovf           <= 1'b0;
      uart_txd      <= 1'b1;
      bus.mem_rdata <= '0;
      bus.mem_ready <= 1'b0;
    end else begin
      state         <= state_next;
      baud_cnt      <= baud_next;
      bit_idx       <= bit_next;
      shift         <= shift_next;
      count         <= count_next;
      ovf           <= ovf_next;
      uart_txd      <= txd_next;
      bus.mem_rdata <= rdata_next;
      bus.mem_ready <= ready_next;
      if (pop)  rd_ptr <= rd_ptr + FIFO_LOG'(1);
      if (push) wr_ptr <= wr_ptr + FIFO_LOG'(1);
    end
  end

  // FIFO storage; pointers are cleared by reset so stale contents are harmless
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.mem_wdata[7:0];
  end

  // Next-state logic: TX sequencing, FIFO occupancy and sticky overflow
  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_idx;
    shift_next = shift;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          state_next = START;
          shift_next = fifo_mem[rd_ptr];
          baud_next  = BAUD_LOAD;
        end
      end
      START: begin
        if (baud_cnt == '0) begin
          state_next = DATA;
          bit_next   = 3'd0;
          baud_next  = BAUD_LOAD;
        end else begin
          baud_next = baud_cnt - BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_cnt == '0) begin
          baud_next = BAUD_LOAD;
          if (bit_idx == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_next   = bit_idx + 3'd1;
            shift_next = shift >> 1;
          end
        end else begin
          baud_next = baud_cnt - BAUD_W'(1);
        end
      end
      default: begin
        if (baud_cnt == '0) begin
          baud_next = BAUD_LOAD;
          if (count != '0) begin
            pop        = 1'b1;
            state_next = START;
            shift_next = fifo_mem[rd_ptr];
          end else begin
            state_next = IDLE;
          end
        end else begin
          baud_next = baud_cnt - BAUD_W'(1);
        end
      end
    endcase

    count_next = count;
    if (push && !pop)      count_next = count + CNT_W'(1);
    else if (pop && !push) count_next = count - CNT_W'(1);

    ovf_next = ovf;
    if (clr_ovf)                      ovf_next = 1'b0;
    else if (push_req && full && !pop) ovf_next = 1'b1;
  end

  // Output logic: line level follows the next state; reads sample current state
  always_comb begin
    txd_next = 1'b1;
    case (state_next)
      START:   txd_next = 1'b0;
      DATA:    txd_next = shift_next[0];
      default: txd_next = 1'b1;
    endcase

    rd_val = '0;
    case (off)
      2'd1:    rd_val = {31'h0, !full};
      2'd2:    rd_val = {16'h0, 8'(count), 5'h0, ovf, busy, !full};
      default: rd_val = '0;
    endcase

    rdata_next = is_rd ? rd_val : 32'h0;
    ready_next = is_rd;
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench: two transmitters (fast and slow baud) on separate buses.
module tb_mmio_uart_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  mmio_uart_tx_if bus_a ();
  mmio_uart_tx_if bus_b ();
  logic txd_a, txd_b;

  mmio_uart_tx #(.BASE(32'hf0000000), .BAUD_DIV(4), .FIFO_LOG(4)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .uart_txd(txd_a)
  );

  mmio_uart_tx #(.BASE(32'hf0000000), .BAUD_DIV(1000), .FIFO_LOG(4)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .uart_txd(txd_b)
  );

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit b, input logic oe, input logic [31:0] a,
                       input logic [3:0] we, input logic [31:0] d);
    if (b) begin
      bus_b.mem_oe = oe; bus_b.mem_addr = a; bus_b.mem_we = we; bus_b.mem_wdata = d;
    end else begin
      bus_a.mem_oe = oe; bus_a.mem_addr = a; bus_a.mem_we = we; bus_a.mem_wdata = d;
    end
  endtask

  // One request cycle; on return the response of that request is visible
  task automatic req(input bit b, input logic [31:0] a, input logic [3:0] we,
                     input logic [31:0] d);
    drive(b, 1'b1, a, we, d);
    cyc();
    drive(b, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  function automatic logic [39:0] frame_exp(input logic [7:0] d);
    logic [9:0]  bits;
    logic [39:0] f;
    bits = {1'b1, d, 1'b0};
    for (int i = 0; i < 40; i++) f[i] = bits[i / 4];
    return f;
  endfunction

  logic [39:0] w40;
  logic [79:0] w80;
  logic [7:0]  dec;
  logic        stuck_low;

  initial begin
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drive(1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
    cyc(); cyc();

    chk("rst_txd_a",   80'(txd_a), 80'd1);
    chk("rst_ready_a", 80'(bus_a.mem_ready), 80'd0);
    chk("rst_rdata_a", 80'(bus_a.mem_rdata), 80'd0);
    rst = 1'b0;
    cyc();

    // Back-to-back reads on the idle slow instance
    req(1'b1, 32'hf0000008, 4'h0, 32'h0);
    chk("status_idle_ready", 80'(bus_b.mem_ready), 80'd1);
    chk("status_idle",       80'(bus_b.mem_rdata), 80'h1);
    drive(1'b1, 1'b1, 32'hf0000004, 4'h0, 32'h0);
    cyc();
    drive(1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
    chk("txdata_rd_ready", 80'(bus_b.mem_ready), 80'd1);
    chk("txdata_rd",       80'(bus_b.mem_rdata), 80'h1);
    cyc();
    chk("ready_drops",     80'(bus_b.mem_ready), 80'd0);
    chk("rdata_zero_idle", 80'(bus_b.mem_rdata), 80'd0);

    // Single frame of 0x41
    req(1'b0, 32'hf0000004, 4'h1, 32'h41);
    chk("txd_before_start", 80'(txd_a), 80'd1);
    cyc();
    for (int i = 0; i < 40; i++) begin
      w40[i] = txd_a;
      cyc();
    end
    chk("frame_41", 80'(w40), 80'(frame_exp(8'h41)));
    chk("idle_after_41", 80'(txd_a), 80'd1);
    req(1'b0, 32'hf0000008, 4'h0, 32'h0);
    chk("status_after_41", 80'(bus_a.mem_rdata), 80'h1);

    // Two bytes back-to-back: no idle gap between frames
    req(1'b0, 32'hf0000004, 4'hf, 32'h55);
    req(1'b0, 32'hf0000004, 4'h1, 32'hAA);
    for (int i = 0; i < 80; i++) begin
      w80[i] = txd_a;
      cyc();
    end
    chk("frame_55_aa", w80, {frame_exp(8'hAA), frame_exp(8'h55)});
    for (int j = 0; j < 8; j++) dec[j] = w80[4 + j*4 + 2];
    chk("rx_byte0", 80'(dec), 80'h55);
    for (int j = 0; j < 8; j++) dec[j] = w80[40 + 4 + j*4 + 2];
    chk("rx_byte1", 80'(dec), 80'hAA);

    // Fill the slow instance: first byte pops at once, 16 more fill the FIFO
    for (int i = 0; i < 17; i++) req(1'b1, 32'hf0000004, 4'h1, 32'(i + 1));
    req(1'b1, 32'hf0000008, 4'h0, 32'h0);
    chk("status_full",   80'(bus_b.mem_rdata), 80'h1002);
    req(1'b1, 32'hf0000004, 4'h0, 32'h0);
    chk("txdata_full",   80'(bus_b.mem_rdata), 80'h0);
    chk("txdata_full_rdy", 80'(bus_b.mem_ready), 80'd1);
    req(1'b1, 32'hf0000004, 4'h1, 32'h99);
    req(1'b1, 32'hf0000008, 4'h0, 32'h0);
    chk("status_ovf",    80'(bus_b.mem_rdata), 80'h1006);
    req(1'b1, 32'hf0000008, 4'hf, 32'h0);
    chk("status_wr_no_ready", 80'(bus_b.mem_ready), 80'd0);
    req(1'b1, 32'hf0000008, 4'h0, 32'h0);
    chk("status_ovf_clr", 80'(bus_b.mem_rdata), 80'h1002);

    // Address decode and byte-enable handling
    req(1'b0, 32'h00001000, 4'h0, 32'h0);
    chk("miss_low_ready", 80'(bus_a.mem_ready), 80'd0);
    req(1'b0, 32'he0000004, 4'h0, 32'h0);
    chk("miss_e_ready",   80'(bus_a.mem_ready), 80'd0);
    req(1'b0, 32'hf0000004, 4'b0010, 32'h0000_3300);
    chk("we1_no_ready",   80'(bus_a.mem_ready), 80'd0);
    stuck_low = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (txd_a !== 1'b1) stuck_low = 1'b1;
      cyc();
    end
    chk("we1_txd_idle", 80'(stuck_low), 80'd0);
    req(1'b0, 32'hf0000008, 4'h0, 32'h0);
    chk("we1_status", 80'(bus_a.mem_rdata), 80'h1);

    // Queue 0x41, read status on the pop cycle, then reset during data bit 3
    req(1'b0, 32'hf0000004, 4'h1, 32'h41);
    chk("write_no_ready", 80'(bus_a.mem_ready), 80'd0);
    req(1'b0, 32'hf0000008, 4'h0, 32'h0);
    chk("status_prepop", 80'(bus_a.mem_rdata), 80'h103);
    chk("start_bit",     80'(txd_a), 80'd0);
    repeat (17) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_mid_txd",   80'(txd_a), 80'd1);
    chk("rst_mid_ready", 80'(bus_a.mem_ready), 80'd0);
    req(1'b0, 32'hf0000008, 4'h0, 32'h0);
    chk("rst_mid_status", 80'(bus_a.mem_rdata), 80'h1);
    req(1'b0, 32'hf0000004, 4'h1, 32'hA5);
    cyc();
    for (int i = 0; i < 40; i++) begin
      w40[i] = txd_a;
      cyc();
    end
    chk("frame_after_rst", 80'(w40), 80'(frame_exp(8'hA5)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
